ctx_stack: RTL and testbench

- Parametrised hardware return/context stack for the single-cycle CPU datapath.
- Successor to the fixed 10-bit call stack. Adds:
  - configurable depth and address width;
  - per-entry saved ALU flags and an interrupt-frame tag, so reti restores z/c;
  - interrupt nesting count, sticky over/underflow, a high-water mark.
- Sits between the PC/incMux path and the flag flip-flops. Driven by the control unit's push/pop strobes.

---
 rtl/ctx_stack.sv | 197 +++++++++++++++++++
 tb/tb_ctx_stack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_stack.sv
// ctx_stack: parametrised return/context stack for the single-cycle CPU.
//
// Each entry holds {pc, saved flags, interrupt tag}. Interrupt pushes (calli)
// save the ALU flags so reti can restore z/c; ordinary calls store zero flags.
// Besides occupancy the block tracks how many interrupt frames are stored,
// a high-water mark, and sticky overflow/underflow flags.
//
// Build option CTX_STACK_WRAP_EN: storage becomes circular with a base
// pointer, and a push into a full stack overwrites the oldest entry instead
// of being dropped.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   push         in   save pc_in (+flags_in, tag) this cycle
//   pop          in   remove top entry this cycle
//   intr         in   marks the push as an interrupt frame
//   pc_in        in   return address to save
//   flags_in     in   flags saved on interrupt push
//   clr_err      in   clears sticky oflow/uflow (wins over a same-cycle set)
//   pc_out       out  top-of-stack PC (0 when empty)
//   flags_out    out  top-of-stack saved flags (0 when empty)
//   top_is_intr  out  top entry is an interrupt frame (0 when empty)
//   level        out  current occupancy
//   intr_level   out  interrupt frames currently stored
//   max_level    out  high-water mark of level since reset
//   empty        out  level == 0
//   full         out  level == DEPTH
//   oflow        out  sticky overflow
//   uflow        out  sticky underflow

module ctx_stack #(
   parameter  int ADDR_W = 10,
   parameter  int DEPTH  = 16,
   parameter  int FLAG_W = 2,
   localparam int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              intr,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] pc_out,
   output logic [FLAG_W-1:0] flags_out,
   output logic              top_is_intr,
   output logic [LVL_W-1:0]  level,
   output logic [LVL_W-1:0]  intr_level,
   output logic [LVL_W-1:0]  max_level,
   output logic              empty,
   output logic              full,
   output logic              oflow,
   output logic              uflow
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW    = ADDR_W + FLAG_W + 1;

   // Entry layout: [EW-1 -: ADDR_W] pc, [FLAG_W:1] flags, [0] interrupt tag
   logic [EW-1:0]    mem_q [DEPTH];

   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] intr_level_q, intr_level_d;
   logic [LVL_W-1:0] max_level_q, max_level_d;
   logic             oflow_q, oflow_d;
   logic             uflow_q, uflow_d;

   logic             is_empty;
   logic             is_full;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] top_idx;
   logic [EW-1:0]    top_entry;
   logic             top_tag;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [EW-1:0]    wr_data;

`ifdef CTX_STACK_WRAP_EN
   logic [IDX_W-1:0] base_q, base_d;
   logic             oldest_tag;

   // (b + off) mod DEPTH; b < DEPTH and off <= DEPTH, so one subtraction suffices
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] b,
                                                 input logic [LVL_W-1:0] off);
      int s;
      s = int'(b) + int'(off);
      if (s >= DEPTH) s = s - DEPTH;
      return IDX_W'(s);
   endfunction

   assign push_idx   = wrap_idx(base_q, level_q);
   // level_q - 1 underflows when empty; top_entry is masked in that case
   assign top_idx    = wrap_idx(base_q, level_q - 1'b1);
   assign oldest_tag = mem_q[base_q][0];
`else
   assign push_idx   = IDX_W'(level_q);
   assign top_idx    = IDX_W'(level_q - 1'b1);
`endif

   assign is_empty  = (level_q == '0);
   assign is_full   = (level_q == LVL_W'(DEPTH));
   assign top_entry = is_empty ? '0 : mem_q[top_idx];
   assign top_tag   = top_entry[0];

   always_comb begin
      level_d      = level_q;
      intr_level_d = intr_level_q;
      oflow_d      = oflow_q;
      uflow_d      = uflow_q;
      wr_en        = 1'b0;
      wr_idx       = push_idx;
      wr_data      = {pc_in, (intr ? flags_in : {FLAG_W{1'b0}}), intr};
`ifdef CTX_STACK_WRAP_EN
      base_d       = base_q;
`endif

      // push&pop on an empty stack degenerates to a plain push
      if (push && (!pop || is_empty)) begin
         if (!is_full) begin
            wr_en        = 1'b1;
            wr_idx       = push_idx;
            level_d      = level_q + 1'b1;
            intr_level_d = intr_level_q + LVL_W'(intr);
         end else begin
            oflow_d = 1'b1;
`ifdef CTX_STACK_WRAP_EN
            // Oldest slot is reused; the base advances so level stays DEPTH
            wr_en        = 1'b1;
            wr_idx       = base_q;
            base_d       = wrap_idx(base_q, LVL_W'(1));
            intr_level_d = intr_level_q - LVL_W'(oldest_tag) + LVL_W'(intr);
`endif
         end
      end else if (push && pop) begin
         wr_en        = 1'b1;
         wr_idx       = top_idx;
         intr_level_d = intr_level_q + LVL_W'(intr) - LVL_W'(top_tag);
      end else if (pop) begin
         if (is_empty) begin
            uflow_d = 1'b1;
         end else begin
            level_d      = level_q - 1'b1;
            // the stored tag, not the intr input, decides the frame type
            intr_level_d = intr_level_q - LVL_W'(top_tag);
         end
      end

      if (clr_err) begin
         oflow_d = 1'b0;
         uflow_d = 1'b0;
      end

      max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q      <= '0;
         intr_level_q <= '0;
         max_level_q  <= '0;
         oflow_q      <= 1'b0;
         uflow_q      <= 1'b0;
`ifdef CTX_STACK_WRAP_EN
         base_q       <= '0;
`endif
      end else begin
         level_q      <= level_d;
         intr_level_q <= intr_level_d;
         max_level_q  <= max_level_d;
         oflow_q      <= oflow_d;
         uflow_q      <= uflow_d;
`ifdef CTX_STACK_WRAP_EN
         base_q       <= base_d;
`endif
      end
   end

   // Storage is not reset; entries beyond level are never observed
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign pc_out      = top_entry[EW-1 -: ADDR_W];
   assign flags_out   = top_entry[FLAG_W:1];
   assign top_is_intr = top_entry[0];
   assign level       = level_q;
   assign intr_level  = intr_level_q;
   assign max_level   = max_level_q;
   assign empty       = is_empty;
   assign full        = is_full;
   assign oflow       = oflow_q;
   assign uflow       = uflow_q;

endmodule

// File: tb/tb_ctx_stack.sv
module tb_ctx_stack;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 16;
   localparam int FLAG_W = 2;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   localparam int S_PC = 0, S_FLG = 1, S_TII = 2, S_LVL = 3, S_ILV = 4,
                  S_MAX = 5, S_EMP = 6, S_FUL = 7, S_OFL = 8, S_UFL = 9;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              push = 1'b0, pop = 1'b0, intr = 1'b0, clr_err = 1'b0;
   logic [ADDR_W-1:0] pc_in = '0;
   logic [FLAG_W-1:0] flags_in = '0;
   logic [ADDR_W-1:0] pc_out;
   logic [FLAG_W-1:0] flags_out;
   logic              top_is_intr, empty, full, oflow, uflow;
   logic [LVL_W-1:0]  level, intr_level, max_level;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   ctx_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FLAG_W(FLAG_W)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .intr(intr),
      .pc_in(pc_in), .flags_in(flags_in), .clr_err(clr_err),
      .pc_out(pc_out), .flags_out(flags_out), .top_is_intr(top_is_intr),
      .level(level), .intr_level(intr_level), .max_level(max_level),
      .empty(empty), .full(full), .oflow(oflow), .uflow(uflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         S_PC:    return 32'(pc_out);
         S_FLG:   return 32'(flags_out);
         S_TII:   return 32'(top_is_intr);
         S_LVL:   return 32'(level);
         S_ILV:   return 32'(intr_level);
         S_MAX:   return 32'(max_level);
         S_EMP:   return 32'(empty);
         S_FUL:   return 32'(full);
         S_OFL:   return 32'(oflow);
         S_UFL:   return 32'(uflow);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic sb_add(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] cur;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         cur = obs(e.sel);
         check_cnt++;
         assert (cur === e.exp) begin
            pass_cnt++;
         end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", e.tag, cur, e.exp);
         end
      end
   endtask

   // one clock with the given strobes; outputs sampled 1 time unit after the edge
   task automatic cyc(input logic p, input logic q, input logic i,
                      input logic [ADDR_W-1:0] pc, input logic [FLAG_W-1:0] f,
                      input logic ce);
      push = p; pop = q; intr = i; pc_in = pc; flags_in = f; clr_err = ce;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; intr = 1'b0; clr_err = 1'b0;
      pc_in = '0; flags_in = '0;
   endtask

   initial begin
      // reset
      #1 reset = 1'b0;
      #2;
      sb_add("rst_level", S_LVL, 0);
      sb_add("rst_ilvl", S_ILV, 0);
      sb_add("rst_max", S_MAX, 0);
      sb_add("rst_empty", S_EMP, 1);
      sb_add("rst_full", S_FUL, 0);
      sb_add("rst_pc", S_PC, 0);
      sb_add("rst_flags", S_FLG, 0);
      sb_add("rst_tii", S_TII, 0);
      sb_add("rst_oflow", S_OFL, 0);
      sb_add("rst_uflow", S_UFL, 0);
      drain();
      @(negedge clk) reset = 1'b1;

      // basic push / pop
      cyc(1, 0, 0, 10'h005, 0, 0);
      cyc(1, 0, 0, 10'h010, 0, 0);
      cyc(1, 0, 0, 10'h3FF, 0, 0);
      sb_add("p3_level", S_LVL, 3);
      sb_add("p3_pc", S_PC, 32'h3FF);
      sb_add("p3_max", S_MAX, 3);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("pop1_pc", S_PC, 32'h010);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("pop2_pc", S_PC, 32'h005);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("pop3_empty", S_EMP, 1);
      sb_add("pop3_pc", S_PC, 0);
      sb_add("pop3_uflow", S_UFL, 0);
      drain();

      // interrupt frame
      cyc(1, 0, 1, 10'h020, 2'b10, 0);
      sb_add("ip_flags", S_FLG, 2);
      sb_add("ip_tii", S_TII, 1);
      sb_add("ip_ilvl", S_ILV, 1);
      sb_add("ip_pc", S_PC, 32'h020);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("ipop_ilvl", S_ILV, 0);
      sb_add("ipop_empty", S_EMP, 1);
      drain();

      // fill to DEPTH and one beyond
      for (int i = 1; i <= DEPTH + 1; i++) begin
         cyc(1, 0, 0, ADDR_W'(i), 0, 0);
         if (i <= DEPTH) begin
            sb_add("fill_pc", S_PC, 32'(i));
            sb_add("fill_level", S_LVL, 32'(i));
            sb_add("fill_oflow", S_OFL, 0);
         end
         drain();
      end
      sb_add("ovf_level", S_LVL, DEPTH);
      sb_add("ovf_full", S_FUL, 1);
      sb_add("ovf_oflow", S_OFL, 1);
      sb_add("ovf_max", S_MAX, DEPTH);
`ifdef CTX_STACK_WRAP_EN
      sb_add("ovf_pc", S_PC, DEPTH + 1);
`else
      sb_add("ovf_pc", S_PC, DEPTH);
`endif
      drain();
      for (int k = 1; k <= DEPTH; k++) begin
         cyc(0, 1, 0, 0, 0, 0);
         sb_add("drain_level", S_LVL, 32'(DEPTH - k));
         if (k == DEPTH) begin
            sb_add("drain_pc", S_PC, 0);
            sb_add("drain_empty", S_EMP, 1);
         end else begin
`ifdef CTX_STACK_WRAP_EN
            sb_add("drain_pc", S_PC, 32'(DEPTH + 1 - k));
`else
            sb_add("drain_pc", S_PC, 32'(DEPTH - k));
`endif
         end
         drain();
      end
      cyc(0, 0, 0, 0, 0, 1);
      sb_add("clr_oflow", S_OFL, 0);
      drain();

      // underflow and clear priority
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("uf_uflow", S_UFL, 1);
      sb_add("uf_level", S_LVL, 0);
      drain();
      cyc(0, 0, 0, 0, 0, 1);
      sb_add("uf_clr", S_UFL, 0);
      drain();
      cyc(0, 1, 0, 0, 0, 1);
      sb_add("uf_clr_prio", S_UFL, 0);
      drain();

      // replace top in place
      cyc(1, 0, 0, 10'h011, 0, 0);
      cyc(1, 0, 0, 10'h022, 0, 0);
      sb_add("rp_pre_level", S_LVL, 2);
      sb_add("rp_pre_tii", S_TII, 0);
      drain();
      cyc(1, 1, 1, 10'h0AA, 2'b01, 0);
      sb_add("rp_level", S_LVL, 2);
      sb_add("rp_pc", S_PC, 32'h0AA);
      sb_add("rp_ilvl", S_ILV, 1);
      sb_add("rp_flags", S_FLG, 1);
      sb_add("rp_tii", S_TII, 1);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("rp_pop_pc", S_PC, 32'h011);
      sb_add("rp_pop_ilvl", S_ILV, 0);
      sb_add("rp_pop_flags", S_FLG, 0);
      drain();
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 10'h033, 0, 0);
      sb_add("pp_empty_level", S_LVL, 1);
      sb_add("pp_empty_pc", S_PC, 32'h033);
      sb_add("pp_empty_uflow", S_UFL, 0);
      drain();
      cyc(0, 1, 0, 0, 0, 0);

      // async reset mid-operation
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, ADDR_W'(10'h100 + i), 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
      sb_add("mid_level", S_LVL, 2);
      sb_add("mid_pc", S_PC, 32'h101);
      sb_add("mid_max", S_MAX, DEPTH);
      drain();
      #3 reset = 1'b0;
      #1;
      sb_add("ar_level", S_LVL, 0);
      sb_add("ar_pc", S_PC, 0);
      sb_add("ar_max", S_MAX, 0);
      sb_add("ar_empty", S_EMP, 1);
      sb_add("ar_ilvl", S_ILV, 0);
      drain();
      @(negedge clk) reset = 1'b1;
      cyc(1, 0, 0, 10'h001, 0, 0);
      sb_add("post_max1", S_MAX, 1);
      sb_add("post_pc", S_PC, 1);
      drain();
      cyc(1, 0, 0, 10'h002, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      sb_add("post_max2", S_MAX, 2);
      sb_add("post_level", S_LVL, 1);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
